// File: rtl/semafor_pkg.sv
// Shared types and default timing for the semafor crossing controller.
package semafor_pkg;

    // State encoding is fixed so the register value is meaningful in waveforms.
    typedef enum logic [2:0] {
        CAR_GREEN  = 3'd0,
        CAR_YELLOW = 3'd1,
        CLEAR1     = 3'd2,
        PED_GREEN  = 3'd3,
        CLEAR2     = 3'd4
    } state_t;

    // Lamp bundle, ordered car red/yellow/green then pedestrian red/green.
    typedef struct packed {
        logic car_red;
        logic car_yellow;
        logic car_green;
        logic ped_red;
        logic ped_green;
    } lamps_t;

    localparam int DEF_T_GREEN  = 20;
    localparam int DEF_T_YELLOW = 3;
    localparam int DEF_T_CLEAR  = 2;
    localparam int DEF_T_PED    = 10;
    localparam int DEF_CNT_W    = 8;

    // Moore lamp decode; unknown states fall back to the safe all-red pattern.
    function automatic lamps_t lamps_of(input state_t s);
        lamps_t l;
        l = '{car_red: 1'b1, car_yellow: 1'b0, car_green: 1'b0, ped_red: 1'b1, ped_green: 1'b0};
        case (s)
            CAR_GREEN:  l = '{car_red: 1'b0, car_yellow: 1'b0, car_green: 1'b1, ped_red: 1'b1, ped_green: 1'b0};
            CAR_YELLOW: l = '{car_red: 1'b0, car_yellow: 1'b1, car_green: 1'b0, ped_red: 1'b1, ped_green: 1'b0};
            PED_GREEN:  l = '{car_red: 1'b1, car_yellow: 1'b0, car_green: 1'b0, ped_red: 1'b0, ped_green: 1'b1};
            default:    l = '{car_red: 1'b1, car_yellow: 1'b0, car_green: 1'b0, ped_red: 1'b1, ped_green: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semafor_if.sv
// Signal bundle between the crossing controller and its environment.
interface semafor_if;
    logic tick;
    logic ped_req;
    logic car_red;
    logic car_yellow;
    logic car_green;
    logic ped_red;
    logic ped_green;
    logic ped_wait;

    // Environment side: drives time base and request, observes lamps.
    modport master (
        output tick, ped_req,
        input  car_red, car_yellow, car_green, ped_red, ped_green, ped_wait
    );

    // Controller side.
    modport slave (
        input  tick, ped_req,
        output car_red, car_yellow, car_green, ped_red, ped_green, ped_wait
    );
endinterface

// File: rtl/semafor_timer.sv
// Tick-enabled dwell counter: clears on state change, saturates at limit-1.
module semafor_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_m1_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    assign done_o = (cnt_q == limit_m1_i);

    // Count ticks; once at limit-1 hold there until the owner clears us.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (tick_i && !done_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/semafor_ctrl.sv
// Car/pedestrian crossing controller: FSM, request latch and registered lamps.
module semafor_ctrl
    import semafor_pkg::*;
#(
    parameter int T_GREEN  = DEF_T_GREEN,
    parameter int T_YELLOW = DEF_T_YELLOW,
    parameter int T_CLEAR  = DEF_T_CLEAR,
    parameter int T_PED    = DEF_T_PED,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    semafor_if.slave    bus
);

    localparam logic [CNT_W-1:0] LIM_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LIM_CLEAR  = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] LIM_PED    = CNT_W'(T_PED - 1);

    state_t           state_q, state_d;
    logic             ped_wait_q, ped_wait_d;
    lamps_t           lamps_q;
    logic [CNT_W-1:0] limit_m1;
    logic             done;
    logic             expire;
    logic             state_chg;

    // Dwell limit for the state we are currently in.
    always_comb begin
        limit_m1 = LIM_CLEAR;
        case (state_q)
            CAR_GREEN:  limit_m1 = LIM_GREEN;
            CAR_YELLOW: limit_m1 = LIM_YELLOW;
            PED_GREEN:  limit_m1 = LIM_PED;
            default:    limit_m1 = LIM_CLEAR;
        endcase
    end

    semafor_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (bus.tick),
        .clr_i      (state_chg),
        .limit_m1_i (limit_m1),
        .done_o     (done)
    );

    assign expire    = bus.tick && done;
    assign state_chg = (state_d != state_q);

    // Next state and request latch; car green only yields to a registered request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CAR_GREEN:  if (expire && ped_wait_q) state_d = CAR_YELLOW;
            CAR_YELLOW: if (expire) state_d = CLEAR1;
            CLEAR1:     if (expire) state_d = PED_GREEN;
            PED_GREEN:  if (expire) state_d = CLEAR2;
            CLEAR2:     if (expire) state_d = CAR_GREEN;
            default:    state_d = CAR_GREEN;
        endcase

        ped_wait_d = ped_wait_q;
        if (state_d == PED_GREEN && state_q != PED_GREEN) begin
            ped_wait_d = 1'b0;
        end else if (bus.ped_req && state_q != PED_GREEN) begin
            ped_wait_d = 1'b1;
        end
    end

    // State, latch and lamp registers; lamps track the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CAR_GREEN;
            ped_wait_q <= 1'b0;
            lamps_q    <= lamps_of(CAR_GREEN);
        end else begin
            state_q    <= state_d;
            ped_wait_q <= ped_wait_d;
            lamps_q    <= lamps_of(state_d);
        end
    end

    assign bus.car_red    = lamps_q.car_red;
    assign bus.car_yellow = lamps_q.car_yellow;
    assign bus.car_green  = lamps_q.car_green;
    assign bus.ped_red    = lamps_q.ped_red;
    assign bus.ped_green  = lamps_q.ped_green;
    assign bus.ped_wait   = ped_wait_q;

endmodule

// File: tb/tb_semafor_ctrl.sv
// Scoreboard bench for semafor_ctrl with short test timings.
module tb_semafor_ctrl;

    logic clk;
    logic rst;
    semafor_if bus();

    semafor_ctrl #(
        .T_GREEN (4),
        .T_YELLOW(2),
        .T_CLEAR (1),
        .T_PED   (3),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamp patterns {car_red, car_yellow, car_green, ped_red, ped_green}.
    localparam logic [4:0] L_G = 5'b00110;
    localparam logic [4:0] L_Y = 5'b01010;
    localparam logic [4:0] L_R = 5'b10010;
    localparam logic [4:0] L_P = 5'b10001;

    typedef struct {
        string      name;
        logic [4:0] lamps;
        logic       wt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle of stimulus and queue the outputs expected after the next edge.
    task automatic step(input logic t, input logic r, input logic rs,
                        input logic [4:0] el, input logic ew, input string nm);
        exp_t e;
        bus.tick    = t;
        bus.ped_req = r;
        rst         = rs;
        e.name  = nm;
        e.lamps = el;
        e.wt    = ew;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic t, input logic r,
                       input logic [4:0] el, input logic ew, input string nm);
        for (int i = 0; i < n; i++) step(t, r, 1'b0, el, ew, nm);
    endtask

    // Monitor: after every edge pop one expectation and compare, plus lamp invariants.
    initial begin : monitor
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {bus.car_red, bus.car_yellow, bus.car_green, bus.ped_red, bus.ped_green};
                checks++;
                if (act !== e.lamps || bus.ped_wait !== e.wt) begin
                    errors++;
                    $display("FAIL %s t=%0t lamps=%b wait=%b expected lamps=%b wait=%b",
                             e.name, $time, act, bus.ped_wait, e.lamps, e.wt);
                end else begin
                    $display("ok   %s t=%0t lamps=%b wait=%b", e.name, $time, act, bus.ped_wait);
                end
                checks++;
                if ((32'(act[4]) + 32'(act[3]) + 32'(act[2])) != 1 ||
                    (32'(act[1]) + 32'(act[0])) != 1 || (act[2] && act[0])) begin
                    errors++;
                    $display("FAIL invariant(%s) t=%0t lamps=%b required one-hot car, one-hot ped, no double green",
                             e.name, $time, act);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst         = 1'b1;
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
        @(negedge clk);

        // 1: reset, then idle car green indefinitely
        run(0, 1'b0, 1'b0, L_G, 1'b0, "");
        step(1'b0, 1'b0, 1'b1, L_G, 1'b0, "reset");
        step(1'b0, 1'b0, 1'b1, L_G, 1'b0, "reset");
        run(50, 1'b1, 1'b0, L_G, 1'b0, "idle_green");

        // 2: full cycle from a fresh reset, request pulse in cycle 1
        step(1'b1, 1'b0, 1'b1, L_G, 1'b0, "full_rst");
        step(1'b1, 1'b0, 1'b0, L_G, 1'b0, "full_g");
        step(1'b1, 1'b1, 1'b0, L_G, 1'b1, "full_req");
        step(1'b1, 1'b0, 1'b0, L_G, 1'b1, "full_g");
        step(1'b1, 1'b0, 1'b0, L_Y, 1'b1, "full_y");
        run(1, 1'b1, 1'b0, L_Y, 1'b1, "full_y");
        run(1, 1'b1, 1'b0, L_R, 1'b1, "full_clr1");
        run(3, 1'b1, 1'b0, L_P, 1'b0, "full_ped");
        run(1, 1'b1, 1'b0, L_R, 1'b0, "full_clr2");
        run(1, 1'b1, 1'b0, L_G, 1'b0, "full_back");

        // 3: request long after the minimum green
        run(10, 1'b1, 1'b0, L_G, 1'b0, "late_idle");
        step(1'b1, 1'b1, 1'b0, L_G, 1'b1, "late_req");
        step(1'b1, 1'b0, 1'b0, L_Y, 1'b1, "late_y");
        run(1, 1'b1, 1'b0, L_Y, 1'b1, "late_y");
        run(1, 1'b1, 1'b0, L_R, 1'b1, "late_clr1");
        run(3, 1'b1, 1'b0, L_P, 1'b0, "late_ped");
        run(1, 1'b1, 1'b0, L_R, 1'b0, "late_clr2");
        run(1, 1'b1, 1'b0, L_G, 1'b0, "late_back");

        // 4: request in PED_GREEN ignored, request in CLEAR2 latched
        step(1'b1, 1'b1, 1'b0, L_G, 1'b1, "ign_req");
        run(2, 1'b1, 1'b0, L_G, 1'b1, "ign_g");
        run(2, 1'b1, 1'b0, L_Y, 1'b1, "ign_y");
        run(1, 1'b1, 1'b0, L_R, 1'b1, "ign_clr1");
        run(1, 1'b1, 1'b0, L_P, 1'b0, "ign_ped");
        step(1'b1, 1'b1, 1'b0, L_P, 1'b0, "ign_ped_req");
        step(1'b1, 1'b0, 1'b0, L_P, 1'b0, "ign_ped");
        step(1'b1, 1'b0, 1'b0, L_R, 1'b0, "ign_clr2");
        step(1'b1, 1'b1, 1'b0, L_G, 1'b1, "clr2_req");
        run(3, 1'b1, 1'b0, L_G, 1'b1, "min_green");
        run(2, 1'b1, 1'b0, L_Y, 1'b1, "min_y");
        run(1, 1'b1, 1'b0, L_R, 1'b1, "min_clr1");
        run(3, 1'b1, 1'b0, L_P, 1'b0, "min_ped");
        run(1, 1'b1, 1'b0, L_R, 1'b0, "min_clr2");
        run(1, 1'b1, 1'b0, L_G, 1'b0, "min_back");

        // 5: sparse tick every fifth cycle, request at start
        step(1'b0, 1'b0, 1'b1, L_G, 1'b0, "sparse_rst");
        for (int i = 0; i < 35; i++) begin
            if (i < 19)      step((i % 5) == 4, i == 0, 1'b0, L_G, 1'b1, "sparse_g");
            else if (i < 29) step((i % 5) == 4, 1'b0, 1'b0, L_Y, 1'b1, "sparse_y");
            else if (i < 34) step((i % 5) == 4, 1'b0, 1'b0, L_R, 1'b1, "sparse_clr1");
            else             step((i % 5) == 4, 1'b0, 1'b0, L_P, 1'b0, "sparse_ped");
        end

        // 6: reset in PED_GREEN, then a full minimum green proves the timer restarted
        step(1'b1, 1'b0, 1'b0, L_P, 1'b0, "mid_ped");
        step(1'b1, 1'b1, 1'b1, L_G, 1'b0, "mid_rst");
        step(1'b1, 1'b1, 1'b0, L_G, 1'b1, "post_rst_req");
        run(2, 1'b1, 1'b0, L_G, 1'b1, "post_rst_g");
        run(1, 1'b1, 1'b0, L_Y, 1'b1, "post_rst_y");

        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
